// File: rtl/inst_queue_feeder.sv
// Serialises icache fetch packets (up to two instructions) into one {pc, inst}
// FIFO write per cycle, and discards responses that were in flight across a flush.
module inst_queue_feeder #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned OUTST_MAX  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           req_issue,
    output logic                           can_issue,
    input  logic                           resp_valid,
    output logic                           resp_ready,
    input  logic [PC_WIDTH-1:0]            resp_pc,
    input  logic [INST_WIDTH-1:0]          resp_inst0,
    input  logic [INST_WIDTH-1:0]          resp_inst1,
    input  logic [1:0]                     resp_mask,
    output logic                           q_write,
    output logic [PC_WIDTH+INST_WIDTH-1:0] q_indata,
    input  logic                           q_full,
    output logic                           busy
);

    localparam int unsigned CW = $clog2(OUTST_MAX) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         pend_q, pend_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [INST_WIDTH-1:0] inst0_q, inst0_d;
    logic [INST_WIDTH-1:0] inst1_q, inst1_d;
    logic [1:0]            mask_q, mask_d;

    logic          wr_ok;
    logic          last_slot;
    logic          fire;
    logic          fire_cnt;
    logic          issue_ok;
    logic          capture_new;
    logic [CW:0]   outst_sum;

    // Emission handshake; one remaining slot lets a new packet overlap its write.
    assign wr_ok       = !q_full && !flush;
    assign last_slot   = (mask_q != 2'b11);
    assign q_write     = (state_q == HOLD) && wr_ok;
    assign resp_ready  = (state_q != HOLD) || (last_slot && wr_ok);
    assign fire        = resp_valid && resp_ready;

    // A response with no outstanding request is ignored so counters never underflow.
    assign fire_cnt    = fire && ((pend_q != '0) || (drop_q != '0));
    assign outst_sum   = {1'b0, pend_q} + {1'b0, drop_q};
    assign can_issue   = (outst_sum < (CW+1)'(OUTST_MAX));
    assign issue_ok    = req_issue && can_issue;
    assign capture_new = fire_cnt && (drop_q == '0) && !flush && (resp_mask != 2'b00);

    assign busy = (state_q != IDLE) || (pend_q != '0) || (drop_q != '0);

    assign q_indata = mask_q[0] ? {pc_q, inst0_q}
                                : {pc_q + PC_WIDTH'(4), inst1_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            drop_q  <= '0;
            pc_q    <= '0;
            inst0_q <= '0;
            inst1_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            pc_q    <= pc_d;
            inst0_q <= inst0_d;
            inst1_q <= inst1_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        drop_d  = drop_q;
        pc_d    = pc_q;
        inst0_d = inst0_q;
        inst1_d = inst1_q;
        mask_d  = mask_q;

        if (flush) begin
            // Everything in flight becomes stale; a request issued now is post-flush.
            drop_d  = drop_q + pend_q - CW'(fire_cnt);
            pend_d  = CW'(issue_ok);
            state_d = (drop_d != '0) ? DROP : IDLE;
        end else begin
            pend_d = pend_q + CW'(issue_ok);
            if (fire_cnt) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    pend_d = pend_d - CW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (capture_new) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (q_write) begin
                        if (last_slot) begin
                            state_d = capture_new ? HOLD
                                    : ((drop_q != '0) ? DROP : IDLE);
                        end else begin
                            mask_d = 2'b10;
                        end
                    end
                end
                DROP: begin
                    if (drop_d == '0) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (capture_new) begin
                pc_d    = resp_pc;
                inst0_d = resp_inst0;
                inst1_d = resp_inst1;
                mask_d  = resp_mask;
            end
        end
    end

endmodule

// File: tb/tb_inst_queue_feeder.sv
// Directed bench for inst_queue_feeder: capture/serialise, back-pressure,
// flush with stale-response dropping, and reset priority.
module tb_inst_queue_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_issue;
    logic        can_issue;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_pc;
    logic [31:0] resp_inst0;
    logic [31:0] resp_inst1;
    logic [1:0]  resp_mask;
    logic        q_write;
    logic [63:0] q_indata;
    logic        q_full;
    logic        busy;

    int passed = 0;
    int total  = 0;

    inst_queue_feeder #(
        .PC_WIDTH  (32),
        .INST_WIDTH(32),
        .OUTST_MAX (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_issue (req_issue),
        .can_issue (can_issue),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_pc   (resp_pc),
        .resp_inst0(resp_inst0),
        .resp_inst1(resp_inst1),
        .resp_mask (resp_mask),
        .q_write   (q_write),
        .q_indata  (q_indata),
        .q_full    (q_full),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic resp(input logic [31:0] pc, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [1:0] m);
        resp_valid = 1'b1;
        resp_pc    = pc;
        resp_inst0 = i0;
        resp_inst1 = i1;
        resp_mask  = m;
    endtask

    task automatic noresp();
        resp_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_issue = 1'b0; q_full = 1'b0;
        resp_valid = 1'b0; resp_pc = '0; resp_inst0 = '0; resp_inst1 = '0; resp_mask = '0;
        step(); step();
        reset = 1'b0; #1;
        chk("rst_q_write",    64'(q_write),    64'd0);
        chk("rst_resp_ready", 64'(resp_ready), 64'd1);
        chk("rst_can_issue",  64'(can_issue),  64'd1);
        chk("rst_busy",       64'(busy),       64'd0);
        step();

        // 1: two-slot packet, one write per cycle
        req_issue = 1'b1; step();
        req_issue = 1'b0; resp(32'h1000, 32'hA000_0000, 32'hA000_0001, 2'b11); #1;
        chk("t1_ready_fire", 64'(resp_ready), 64'd1);
        chk("t1_no_comb_wr", 64'(q_write),    64'd0);
        step();
        noresp(); #1;
        chk("t1_wr0",       64'(q_write),    64'd1);
        chk("t1_data0",     q_indata,        {32'h1000, 32'hA000_0000});
        chk("t1_ready_two", 64'(resp_ready), 64'd0);
        step(); #1;
        chk("t1_wr1",       64'(q_write),    64'd1);
        chk("t1_data1",     q_indata,        {32'h1004, 32'hA000_0001});
        chk("t1_ready_one", 64'(resp_ready), 64'd1);
        step(); #1;
        chk("t1_idle_wr",   64'(q_write),    64'd0);
        chk("t1_busy",      64'(busy),       64'd0);
        step();

        // 2: slot-1-only packet, then an empty packet
        req_issue = 1'b1; step();
        resp(32'h2000, 32'hB000_0000, 32'hB000_0001, 2'b10); step();
        req_issue = 1'b0; noresp(); #1;
        chk("t2_wr",    64'(q_write), 64'd1);
        chk("t2_data",  q_indata,     {32'h2004, 32'hB000_0001});
        step();
        resp(32'h3000, 32'hC000_0000, 32'hC000_0001, 2'b00); #1;
        chk("t2_m0_ready", 64'(resp_ready), 64'd1);
        chk("t2_m0_nowr",  64'(q_write),    64'd0);
        step();
        noresp(); #1;
        chk("t2_m0_nowr2", 64'(q_write),      64'd0);
        chk("t2_pend",     64'(dut.pend_q),   64'd0);
        chk("t2_state",    64'(dut.state_q),  64'd0);
        chk("t2_busy",     64'(busy),         64'd0);
        step();

        // 3: back-pressure while holding a two-slot packet
        req_issue = 1'b1; step(); step();
        req_issue = 1'b0; q_full = 1'b1;
        resp(32'h4000, 32'hD000_0000, 32'hD000_0001, 2'b11); step();
        resp(32'h5000, 32'hE000_0000, 32'hE000_0001, 2'b11);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_full_nowr",  64'(q_write),    64'd0);
            chk("t3_full_ready", 64'(resp_ready), 64'd0);
            step();
        end
        q_full = 1'b0; #1;
        chk("t3_wr0",    64'(q_write),    64'd1);
        chk("t3_data0",  q_indata,        {32'h4000, 32'hD000_0000});
        chk("t3_rdy0",   64'(resp_ready), 64'd0);
        step(); #1;
        chk("t3_wr1",    64'(q_write),    64'd1);
        chk("t3_data1",  q_indata,        {32'h4004, 32'hD000_0001});
        chk("t3_rdy1",   64'(resp_ready), 64'd1);
        step();
        noresp(); #1;
        chk("t3_wr2",    64'(q_write),    64'd1);
        chk("t3_data2",  q_indata,        {32'h5000, 32'hE000_0000});
        step(); #1;
        chk("t3_wr3",    64'(q_write),    64'd1);
        chk("t3_data3",  q_indata,        {32'h5004, 32'hE000_0001});
        step(); #1;
        chk("t3_end_wr",   64'(q_write), 64'd0);
        chk("t3_end_busy", 64'(busy),    64'd0);
        step();

        // 4: flush with three requests in flight, then drop them
        req_issue = 1'b1; step(); step(); step();
        req_issue = 1'b0; flush = 1'b1; #1;
        chk("t4_flush_nowr", 64'(q_write), 64'd0);
        step();
        flush = 1'b0; #1;
        chk("t4_drop_cnt", 64'(dut.drop_q),  64'd3);
        chk("t4_state",    64'(dut.state_q), 64'd2);
        chk("t4_busy",     64'(busy),        64'd1);
        resp(32'h9000, 32'hF000_0000, 32'hF000_0001, 2'b11); req_issue = 1'b1; #1;
        chk("t4_drop_rdy", 64'(resp_ready), 64'd1);
        chk("t4_drop_wr0", 64'(q_write),    64'd0);
        step();
        req_issue = 1'b0; #1;
        chk("t4_drop_wr1", 64'(q_write), 64'd0);
        step(); #1;
        chk("t4_drop_wr2", 64'(q_write), 64'd0);
        step();
        noresp(); #1;
        chk("t4_post_wr",    64'(q_write),     64'd0);
        chk("t4_post_state", 64'(dut.state_q), 64'd0);
        chk("t4_post_drop",  64'(dut.drop_q),  64'd0);
        chk("t4_post_pend",  64'(dut.pend_q),  64'd1);
        step();
        resp(32'h6000, 32'h1111_0000, 32'h1111_0001, 2'b01); step();
        noresp(); #1;
        chk("t4_new_wr",   64'(q_write),    64'd1);
        chk("t4_new_data", q_indata,        {32'h6000, 32'h1111_0000});
        chk("t4_new_rdy",  64'(resp_ready), 64'd1);
        step(); #1;
        chk("t4_done_wr",   64'(q_write), 64'd0);
        chk("t4_done_busy", 64'(busy),    64'd0);
        step();

        // 5: flush coincident with a fire and a new request
        req_issue = 1'b1; step(); step();
        flush = 1'b1; resp(32'h7000, 32'h2222_0000, 32'h2222_0001, 2'b11); #1;
        chk("t5_rdy",  64'(resp_ready), 64'd1);
        chk("t5_nowr", 64'(q_write),    64'd0);
        step();
        flush = 1'b0; req_issue = 1'b0; noresp(); #1;
        chk("t5_drop",  64'(dut.drop_q),  64'd1);
        chk("t5_pend",  64'(dut.pend_q),  64'd1);
        chk("t5_state", 64'(dut.state_q), 64'd2);
        chk("t5_nowr2", 64'(q_write),     64'd0);
        resp(32'h7100, 32'h3333_0000, 32'h3333_0001, 2'b11); step();
        resp(32'h7200, 32'h3333_1000, 32'h3333_1001, 2'b00); step();
        noresp(); #1;
        chk("t5_clean_busy", 64'(busy), 64'd0);
        // flush kills a held packet
        req_issue = 1'b1; step();
        req_issue = 1'b0; resp(32'h7300, 32'h4444_0000, 32'h4444_0001, 2'b11); step();
        noresp(); flush = 1'b1; #1;
        chk("t5_hold_flush_wr",  64'(q_write),    64'd0);
        chk("t5_hold_flush_rdy", 64'(resp_ready), 64'd0);
        step();
        flush = 1'b0; #1;
        chk("t5_killed_wr",    64'(q_write),     64'd0);
        chk("t5_killed_state", 64'(dut.state_q), 64'd0);
        chk("t5_killed_busy",  64'(busy),        64'd0);
        step();

        // 6: fill the outstanding window, then reset mid-HOLD under q_full
        req_issue = 1'b1; step(); step(); step(); step(); #1;
        chk("t6_can_issue0", 64'(can_issue), 64'd0);
        step();
        req_issue = 1'b0; #1;
        chk("t6_pend_sat", 64'(dut.pend_q), 64'd4);
        chk("t6_busy",     64'(busy),       64'd1);
        q_full = 1'b1; resp(32'h8000, 32'h5555_0000, 32'h5555_0001, 2'b11); step();
        noresp(); #1;
        chk("t6_hold_state", 64'(dut.state_q), 64'd1);
        chk("t6_hold_nowr",  64'(q_write),     64'd0);
        chk("t6_hold_rdy",   64'(resp_ready),  64'd0);
        chk("t6_can_issue1", 64'(can_issue),   64'd1);
        reset = 1'b1; step();
        reset = 1'b0; q_full = 1'b0; #1;
        chk("t6_rst_pend",  64'(dut.pend_q),  64'd0);
        chk("t6_rst_drop",  64'(dut.drop_q),  64'd0);
        chk("t6_rst_state", 64'(dut.state_q), 64'd0);
        chk("t6_rst_can",   64'(can_issue),   64'd1);
        chk("t6_rst_wr",    64'(q_write),     64'd0);
        chk("t6_rst_rdy",   64'(resp_ready),  64'd1);
        chk("t6_rst_busy",  64'(busy),        64'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/inst_queue_feeder.md
Name: inst_queue_feeder

Overview:
- Sits directly upstream of the instruction FIFO (64-bit entries) between the icache response path and decode.
- Accepts fetch packets of up to two instructions, serialises them into one {pc, inst} FIFO write per cycle, and applies back-pressure to the icache.
- Tracks outstanding icache requests so responses that were already in flight when a pipeline flush occurs are discarded rather than enqueued.

Parameters:
- PC_WIDTH, 32, width of the fetch address.
- INST_WIDTH, 32, width of one instruction word.
- OUTST_MAX, 4, maximum in-flight icache requests (pending plus stale); counters are $clog2(OUTST_MAX)+1 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline redirect; kills the held packet and all in-flight requests
- req_issue  in  1  fetch stage issued one icache request this cycle
- can_issue  out  1  (pend_cnt+drop_cnt) < OUTST_MAX
- resp_valid  in  1  icache response valid
- resp_ready  out  1  feeder accepts the response this cycle
- resp_pc  in  PC_WIDTH  address of slot 0; slot 1 is at resp_pc+4
- resp_inst0  in  INST_WIDTH  slot 0 instruction
- resp_inst1  in  INST_WIDTH  slot 1 instruction
- resp_mask  in  2  bit0 = slot 0 valid, bit1 = slot 1 valid
- q_write  out  1  FIFO write strobe
- q_indata  out  PC_WIDTH+INST_WIDTH  {pc, inst}, pc in the MSBs
- q_full  in  1  FIFO full
- busy  out  1  state != IDLE or pend_cnt != 0 or drop_cnt != 0

Behaviour:
- Fire: fire = resp_valid & resp_ready.
- States:
  - IDLE: no packet held.
  - HOLD: packet register holds 1–2 unsent slots.
  - DROP: drop_cnt != 0 and no packet held.
- resp_ready:
  - Always 1 in IDLE and DROP.
  - In HOLD, 1 only when exactly one slot remains and it is written this cycle (!q_full & !flush).
  - Combinational from q_full.
- Capture:
  - A fire with drop_cnt==0 and !flush latches pc, both instructions and the mask, then goes to HOLD.
  - If the mask is 2'b00, the packet is consumed with no write and the state stays IDLE.
- Emission:
  - In HOLD, q_write = !q_full & !flush.
  - Slots are written lowest valid slot first, one per cycle.
  - Slot 1 pc = captured pc + 4, modulo 2^PC_WIDTH.
  - After the last slot is written: state becomes HOLD if a new packet fires in the same cycle; otherwise IDLE, or DROP if drop_cnt != 0.
- Latency: first q_write occurs 1 cycle after fire. There is no combinational path from resp_* to q_*.
- Sustained throughput: one entry per cycle. A two-slot packet occupies 2 cycles; back-to-back packets incur no bubble.
- q_indata when q_write=0: holds its last value (don't-care).
- Counters, no flush:
  - pend_cnt += req_issue.
  - On fire: drop_cnt-- if drop_cnt != 0, else pend_cnt--.
  - A fire with both counters zero is a protocol error: it is ignored and counters do not underflow.
  - req_issue while !can_issue is a protocol error; counters saturate.
- Flush cycle:
  - Held packet discarded; q_write = 0.
  - drop_cnt <= drop_cnt + pend_cnt - fire.
  - pend_cnt <= req_issue (a request issued in the flush cycle is post-flush).
  - A response firing in the flush cycle is discarded.
  - Next state is DROP if the new drop_cnt != 0, else IDLE.
- DROP:
  - Every fire decrements drop_cnt and produces no write.
  - Leave to IDLE when drop_cnt reaches 0.
  - The first response after that is captured normally.
- FIFO side: the FIFO is cleared by the same flush externally. The feeder never writes in a flush cycle.
- Reset: state IDLE, pend_cnt=0, drop_cnt=0. After reset q_write=0, resp_ready=1, can_issue=1, busy=0. Reset has priority over flush and all inputs, including mid-packet and mid-DROP.

Test Plan:
1. Reset, then issue 1 request and return pc=0x1000, mask=2'b11, q_full=0.
   - q_write on cycles t+1 and t+2.
   - Data {0x1000,inst0} then {0x1004,inst1}.
   - resp_ready=1 on t+2; busy=0 after.
2. Mask 2'b10 at pc=0x2000 → single write {0x2004,inst1}. Mask 2'b00 → no write, pend_cnt decrements.
3. Hold q_full=1 for 5 cycles with a 2-slot packet held, then release.
   - q_write=0 and resp_ready=0 while full.
   - After release, writes on consecutive cycles; a second packet is accepted on the second-write cycle with no bubble.
4. Issue 3 requests, assert flush with no response.
   - drop_cnt=3, state DROP, q_write=0.
   - The next 3 responses are consumed without writes; the 4th (post-flush) response is enqueued.
5. Flush coincident with a response fire and a req_issue, with pend=2.
   - drop_cnt=1, pend_cnt=1, held packet killed, no write that cycle.
6. Issue OUTST_MAX requests → can_issue=0. Assert reset while in HOLD with q_full=1 → next cycle counters 0, state IDLE, can_issue=1, q_write=0.
